sdram_refresh_sched: RTL and testbench

SDRAM_REFRESH_SCHED -- requirements
Module: sdram_refresh_sched

---
 rtl/sdram_refresh_sched_if.sv | 35 +++
 rtl/sdram_refresh_sched.sv | 173 +++++++++++++++++
 tb/tb_sdram_refresh_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sdram_refresh_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : sdram_refresh_sched_if
// Brief   : Arbiter-side bundle for the SDRAM refresh scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface sdram_refresh_sched_if #(
    parameter int MAX_DEBT = 8
) ();
    localparam int c_DEBT_W = $clog2(MAX_DEBT + 1);

    logic                i_init_done;
    logic                i_refresh_start;
    logic                o_refresh_request;
    logic                o_refresh_urgent;
    logic [3:0]          o_refresh_cmd;
    logic [1:0]          o_refresh_ba;
    logic [12:0]         o_refresh_addr;
    logic                o_refresh_done;
    logic [c_DEBT_W-1:0] o_refresh_debt;
    logic                o_refresh_overflow;

    modport master (
        output i_init_done, i_refresh_start,
        input  o_refresh_request, o_refresh_urgent, o_refresh_cmd, o_refresh_ba,
               o_refresh_addr, o_refresh_done, o_refresh_debt, o_refresh_overflow
    );

    modport slave (
        input  i_init_done, i_refresh_start,
        output o_refresh_request, o_refresh_urgent, o_refresh_cmd, o_refresh_ba,
               o_refresh_addr, o_refresh_done, o_refresh_debt, o_refresh_overflow
    );
endinterface
`default_nettype wire

// File: rtl/sdram_refresh_sched.sv
`default_nettype none
// ============================================================================
// Module  : sdram_refresh_sched
// Brief   : Tracks owed SDRAM refreshes and issues PRECHARGE-ALL + AUTO
//           REFRESH bursts when granted by the memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_refresh_sched #(
    parameter int CLK_PER_REF   = 750,
    parameter int REF_PER_BURST = 2,
    parameter int TRP_CLK       = 2,
    parameter int TRFC_CLK      = 7,
    parameter int MAX_DEBT      = 8,
    parameter int URGENT_TH     = 6
) (
    input  wire logic              i_sysclk,
    input  wire logic              i_sysrst_n,
    sdram_refresh_sched_if.slave   bus
);
    localparam int c_DEBT_W   = $clog2(MAX_DEBT + 1);
    localparam int c_CNT_W    = (CLK_PER_REF > 1) ? $clog2(CLK_PER_REF) : 1;
    localparam int c_WAIT_MAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
    localparam int c_WAIT_W   = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(CLK_PER_REF - 1);
    localparam logic [c_WAIT_W-1:0] c_TRP_LOAD  = c_WAIT_W'(TRP_CLK - 1);
    localparam logic [c_WAIT_W-1:0] c_TRFC_LOAD = c_WAIT_W'(TRFC_CLK - 1);
    localparam logic [c_DEBT_W-1:0] c_DEBT_MAX  = c_DEBT_W'(MAX_DEBT);
    localparam logic [c_DEBT_W-1:0] c_URG_TH    = c_DEBT_W'(URGENT_TH);
    localparam logic [c_DEBT_W-1:0] c_BURST     = c_DEBT_W'(REF_PER_BURST);

    localparam logic [3:0] c_CMD_NOP = 4'b0111;
    localparam logic [3:0] c_CMD_PCH = 4'b0010;
    localparam logic [3:0] c_CMD_REF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PCH  = 3'd1,
        S_TRP  = 3'd2,
        S_REF  = 3'd3,
        S_TRFC = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_DEBT_W-1:0]  r_debt;
    logic [c_DEBT_W-1:0]  r_issued;
    logic [c_DEBT_W-1:0]  r_limit;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [3:0]           r_cmd;
    logic [1:0]           r_ba;
    logic [12:0]          r_addr;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_tick;
    logic                 w_issue;
    logic                 w_request;
    logic                 w_urgent;
    logic                 w_more;
    logic                 w_grant;
    logic                 w_wait_ld;
    logic [c_WAIT_W-1:0]  w_wait_val;
    logic [3:0]           w_cmd_nxt;
    logic                 w_done_nxt;

    assign w_tick    = bus.i_init_done && (r_cnt == c_CNT_LAST);
    assign w_request = (r_state == S_IDLE) && (r_debt != '0) && bus.i_init_done;
    assign w_urgent  = (r_debt >= c_URG_TH);
    assign w_more    = (r_debt != '0) && (r_issued < r_limit);
    // REF lasts exactly one cycle, so entering it is the issue event
    assign w_issue   = (w_state_nxt == S_REF);

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_wait_ld   = 1'b0;
        w_wait_val  = '0;
        w_cmd_nxt   = c_CMD_NOP;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_request && bus.i_refresh_start) begin
                    w_state_nxt = S_PCH;
                    w_grant     = 1'b1;
                end
            end
            S_PCH: begin
                w_state_nxt = S_TRP;
                w_wait_ld   = 1'b1;
                w_wait_val  = c_TRP_LOAD;
            end
            S_TRP: begin
                if (r_wait == '0) w_state_nxt = S_REF;
            end
            S_REF: begin
                w_state_nxt = S_TRFC;
                w_wait_ld   = 1'b1;
                w_wait_val  = c_TRFC_LOAD;
            end
            S_TRFC: begin
                if (r_wait == '0) w_state_nxt = w_more ? S_REF : S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Outputs are decoded from the next state so the registered copies line up with it
        case (w_state_nxt)
            S_PCH:   w_cmd_nxt  = c_CMD_PCH;
            S_REF:   w_cmd_nxt  = c_CMD_REF;
            S_DONE:  w_done_nxt = 1'b1;
            default: w_cmd_nxt  = c_CMD_NOP;
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            r_cnt    <= '0;
            r_debt   <= '0;
            r_issued <= '0;
            r_limit  <= '0;
            r_wait   <= '0;
            r_cmd    <= c_CMD_NOP;
            r_ba     <= 2'b11;
            r_addr   <= 13'h1fff;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_cmd  <= w_cmd_nxt;
            r_done <= w_done_nxt;

            if (!bus.i_init_done || w_tick) r_cnt <= '0;
            else                            r_cnt <= r_cnt + 1'b1;

            if (w_tick && !w_issue) begin
                if (r_debt == c_DEBT_MAX) r_ovf  <= 1'b1;
                else                      r_debt <= r_debt + 1'b1;
            end else if (w_issue && !w_tick) begin
                r_debt <= r_debt - 1'b1;
            end

            if (w_grant) begin
                r_issued <= '0;
                r_limit  <= w_urgent ? c_DEBT_MAX : c_BURST;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end

            if (w_wait_ld)          r_wait <= w_wait_val;
            else if (r_wait != '0)  r_wait <= r_wait - 1'b1;
        end
    end

    assign bus.o_refresh_request  = w_request;
    assign bus.o_refresh_urgent   = w_urgent;
    assign bus.o_refresh_cmd      = r_cmd;
    assign bus.o_refresh_ba       = r_ba;
    assign bus.o_refresh_addr     = r_addr;
    assign bus.o_refresh_done     = r_done;
    assign bus.o_refresh_debt     = r_debt;
    assign bus.o_refresh_overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_sdram_refresh_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_refresh_sched
// Brief   : Directed bench for sdram_refresh_sched with a command scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdram_refresh_sched;
    localparam logic [3:0] c_NOP = 4'b0111;
    localparam logic [3:0] c_PCH = 4'b0010;
    localparam logic [3:0] c_AR  = 4'b0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   base  = 0;
    int   total = 0;
    int   bad   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_refresh_sched_if #(.MAX_DEBT(8)) bus ();

    sdram_refresh_sched dut (
        .i_sysclk   (clk),
        .i_sysrst_n (rst_n),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc - base < n) @(negedge clk);
    endtask

    // Expected {done, cmd} per cycle: PRECHARGE, tRP NOPs, nref x (AR + tRFC NOPs), DONE
    task automatic push_seq(input int nref);
        sb.push_back({1'b0, c_PCH});
        repeat (2) sb.push_back({1'b0, c_NOP});
        for (int k = 0; k < nref; k++) begin
            sb.push_back({1'b0, c_AR});
            repeat (7) sb.push_back({1'b0, c_NOP});
        end
        sb.push_back({1'b1, c_NOP});
    endtask

    task automatic grant_seq(input string tag, input int nref, input int off, input int off_debt);
        logic [4:0] e;
        int idx;
        idx = 0;
        push_seq(nref);
        bus.i_refresh_start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            bus.i_refresh_start = 1'b0;
            e = sb.pop_front();
            chk({tag, "_cmd"}, {27'd0, bus.o_refresh_done, bus.o_refresh_cmd}, {27'd0, e});
            if (idx == 0)   chk({tag, "_reqdrop"}, {31'd0, bus.o_refresh_request}, 32'd0);
            if (idx == off) chk({tag, "_middebt"}, 32'(bus.o_refresh_debt), off_debt);
            idx++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_init_done     = 1'b0;
        bus.i_refresh_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",  32'(bus.o_refresh_cmd),      32'h7);
        chk("rst_ba",   32'(bus.o_refresh_ba),       32'h3);
        chk("rst_addr", 32'(bus.o_refresh_addr),     32'h1fff);
        chk("rst_debt", 32'(bus.o_refresh_debt),     32'd0);
        chk("rst_req",  32'(bus.o_refresh_request),  32'd0);
        chk("rst_urg",  32'(bus.o_refresh_urgent),   32'd0);
        chk("rst_done", 32'(bus.o_refresh_done),     32'd0);
        chk("rst_ovf",  32'(bus.o_refresh_overflow), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        bus.i_refresh_start = 1'b1;
        @(negedge clk);
        bus.i_refresh_start = 1'b0;
        @(negedge clk);
        chk("ign_grant_cmd", 32'(bus.o_refresh_cmd), 32'h7);

        bus.i_init_done = 1'b1;
        base = cyc;
        wait_until(749);
        chk("int_req_pre",  32'(bus.o_refresh_request), 32'd0);
        chk("int_debt_pre", 32'(bus.o_refresh_debt),    32'd0);
        wait_until(750);
        chk("int_req",  32'(bus.o_refresh_request), 32'd1);
        chk("int_debt", 32'(bus.o_refresh_debt),    32'd1);
        wait_until(770);
        chk("int_req_hold", 32'(bus.o_refresh_request), 32'd1);

        grant_seq("one", 1, -1, 0);
        @(negedge clk);
        chk("one_debt", 32'(bus.o_refresh_debt),    32'd0);
        chk("one_req",  32'(bus.o_refresh_request), 32'd0);

        wait_until(3000);
        chk("b2_debt_pre", 32'(bus.o_refresh_debt), 32'd3);
        grant_seq("b2", 2, -1, 0);
        @(negedge clk);
        chk("b2_req",  32'(bus.o_refresh_request), 32'd1);
        chk("b2_debt", 32'(bus.o_refresh_debt),    32'd1);

        wait_until(6750);
        chk("urg_debt_pre", 32'(bus.o_refresh_debt),   32'd6);
        chk("urg_flag",     32'(bus.o_refresh_urgent), 32'd1);
        grant_seq("urg", 6, -1, 0);
        @(negedge clk);
        chk("urg_debt", 32'(bus.o_refresh_debt),    32'd0);
        chk("urg_clr",  32'(bus.o_refresh_urgent),  32'd0);
        chk("urg_req",  32'(bus.o_refresh_request), 32'd0);

        // Grant timed so the first AUTO REFRESH lands on the interval tick
        wait_until(8246);
        chk("coin_debt_pre", 32'(bus.o_refresh_debt), 32'd1);
        grant_seq("coin", 2, 3, 1);
        @(negedge clk);
        chk("coin_debt", 32'(bus.o_refresh_debt), 32'd0);

        wait_until(14250);
        chk("sat_debt8", 32'(bus.o_refresh_debt),     32'd8);
        chk("sat_ovf0",  32'(bus.o_refresh_overflow), 32'd0);
        wait_until(15000);
        chk("sat_debt",  32'(bus.o_refresh_debt),     32'd8);
        chk("sat_ovf",   32'(bus.o_refresh_overflow), 32'd1);
        chk("sat_urg",   32'(bus.o_refresh_urgent),   32'd1);

        bus.i_refresh_start = 1'b1;
        @(negedge clk);
        bus.i_refresh_start = 1'b0;
        chk("mid_pch",    32'(bus.o_refresh_cmd),      32'(c_PCH));
        chk("mid_sticky", 32'(bus.o_refresh_overflow), 32'd1);
        wait_until(15004);
        chk("mid_ar",   32'(bus.o_refresh_cmd),  32'(c_AR));
        chk("mid_debt", 32'(bus.o_refresh_debt), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cmd",  32'(bus.o_refresh_cmd),      32'h7);
        chk("arst_debt", 32'(bus.o_refresh_debt),     32'd0);
        chk("arst_ovf",  32'(bus.o_refresh_overflow), 32'd0);
        chk("arst_req",  32'(bus.o_refresh_request),  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_hold", 32'(bus.o_refresh_cmd), 32'h7);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
